// File: rtl/mux_4_pkg.sv
// rtl/mux_4_pkg.sv - shared constants for the register-file write-address selector
//
// Purpose: holds the register index width that the selector uses by default.
package mux_4_pkg;

  // Width of a register index (32 architectural registers).
  localparam int REG_IDX_W = 5;

endpackage : mux_4_pkg

// File: rtl/mux_4_mux2.sv
// rtl/mux_4_mux2.sv - generic WIDTH-bit 2:1 combinational mux
//
// Purpose: pure combinational select, no state.
// Ports:
//   a    input  WIDTH : chosen when sel = 1
//   b    input  WIDTH : chosen when sel = 0
//   sel  input  1     : select
//   y    output WIDTH : selected value
module mux_4_mux2 #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? a : b;

endmodule : mux_4_mux2

// File: rtl/mux_4.sv
// rtl/mux_4.sv - register-file write-address selector with registered copy
//
// Purpose: picks the destination register index (rd-type field or rt field)
// and also provides a one-cycle registered copy for pipelined/debug consumers.
// Ports:
//   clk             input  1     : clock, rising-edge
//   rst             input  1     : synchronous reset, active-low
//   write_reg_temp  input  WIDTH : candidate A (rd-type field)
//   read_reg2       input  WIDTH : candidate B (rt field)
//   RegDst          input  1     : 1 selects write_reg_temp, 0 selects read_reg2
//   write_reg       output WIDTH : combinational selected index
//   write_reg_q     output WIDTH : write_reg registered one cycle
//   RegDst_q        output 1     : RegDst registered one cycle
module mux_4
  import mux_4_pkg::*;
#(
  parameter int WIDTH = REG_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] write_reg_temp,
  input  logic [WIDTH-1:0] read_reg2,
  input  logic             RegDst,
  output logic [WIDTH-1:0] write_reg,
  output logic [WIDTH-1:0] write_reg_q,
  output logic             RegDst_q
);

  // Index 0 passes through untouched; the register file suppresses $zero writes.
  mux_4_mux2 #(
    .WIDTH(WIDTH)
  ) u_mux2 (
    .a  (write_reg_temp),
    .b  (read_reg2),
    .sel(RegDst),
    .y  (write_reg)
  );

  // Reloads every cycle; no enable or hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_reg_q <= '0;
      RegDst_q    <= 1'b0;
    end else begin
      write_reg_q <= write_reg;
      RegDst_q    <= RegDst;
    end
  end

endmodule : mux_4

// File: tb/tb_mux_4.sv
// tb/tb_mux_4.sv - self-checking bench for mux_4
module tb_mux_4;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic         sel = 1'b0;
  logic [W-1:0] write_reg;
  logic [W-1:0] write_reg_q;
  logic         RegDst_q;

  int checks = 0;
  int errors = 0;

  mux_4 #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .write_reg_temp(a),
    .read_reg2     (b),
    .RegDst        (sel),
    .write_reg     (write_reg),
    .write_reg_q   (write_reg_q),
    .RegDst_q      (RegDst_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the selected index and what the register stage must hold.
  function automatic logic [W-1:0] pick(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    if (s == 1'b1) return x;
    return y;
  endfunction

  logic [W-1:0] m_q;
  logic         m_sel_q;
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst == 1'b0) begin
      m_q     = '0;
      m_sel_q = 1'b0;
    end else begin
      m_q     = pick(sel, a, b);
      m_sel_q = sel;
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    check("model_write_reg", 32'(write_reg), 32'(pick(sel, a, b)));
    if (m_valid) begin
      check("model_write_reg_q", 32'(write_reg_q), 32'(m_q));
      check("model_RegDst_q", 32'(RegDst_q), 32'(m_sel_q));
    end
  end

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    rst = 1'b0; a = 5'd17; b = 5'd9; sel = 1'b1;
    edge_wait();
    check("reset_q", 32'(write_reg_q), 32'd0);
    check("reset_sel_q", 32'(RegDst_q), 32'd0);
    check("reset_comb_tracks", 32'(write_reg), 32'd17);

    // Select A
    rst = 1'b1;
    #1 check("selA_comb", 32'(write_reg), 32'd17);
    edge_wait();
    check("selA_q", 32'(write_reg_q), 32'd17);
    check("selA_sel_q", 32'(RegDst_q), 32'd1);

    // Select B
    sel = 1'b0;
    #1 check("selB_comb", 32'(write_reg), 32'd9);
    edge_wait();
    check("selB_q", 32'(write_reg_q), 32'd9);
    check("selB_sel_q", 32'(RegDst_q), 32'd0);

    // Extremes, lag by one cycle
    a = 5'd31; b = 5'd0; sel = 1'b1;
    #1 check("ext_comb_31", 32'(write_reg), 32'd31);
    edge_wait();
    check("ext_q_31", 32'(write_reg_q), 32'd31);
    sel = 1'b0;
    #1 check("ext_comb_0", 32'(write_reg), 32'd0);
    check("ext_q_lag", 32'(write_reg_q), 32'd31);
    edge_wait();
    check("ext_q_0", 32'(write_reg_q), 32'd0);
    check("ext_sel_q_0", 32'(RegDst_q), 32'd0);

    // Reset mid-stream
    sel = 1'b1;
    edge_wait();
    check("pre_rst_q", 32'(write_reg_q), 32'd31);
    check("pre_rst_sel_q", 32'(RegDst_q), 32'd1);
    rst = 1'b0;
    a = 5'd12;
    #1 check("rst_comb_tracks", 32'(write_reg), 32'd12);
    edge_wait();
    check("rst_q", 32'(write_reg_q), 32'd0);
    check("rst_sel_q", 32'(RegDst_q), 32'd0);
    check("rst_comb_after", 32'(write_reg), 32'd12);
    rst = 1'b1;
    edge_wait();
    check("release_q", 32'(write_reg_q), 32'd12);
    check("release_sel_q", 32'(RegDst_q), 32'd1);

    // Reset pulse between edges has no effect
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check("pulse_q_between", 32'(write_reg_q), 32'd12);
    edge_wait();
    check("pulse_q", 32'(write_reg_q), 32'd12);
    check("pulse_sel_q", 32'(RegDst_q), 32'd1);

    // Random sweep; the negedge compare process checks every cycle
    for (int i = 0; i < 1000; i++) begin
      a   = W'($urandom_range(0, 31));
      b   = W'($urandom_range(0, 31));
      sel = 1'($urandom_range(0, 1));
      edge_wait();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux_4
